// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the boot-time program loader.
//   state_e        : loader FSM states
//   LEN_BYTES      : bytes in the little-endian word-count header
//   BYTES_PER_WORD : bytes packed into one instruction word
//   csum_update()  : running XOR checksum step over the byte stream
// ---------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Fold one stream byte into the running XOR checksum.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Collects a little-endian stream of bytes into instruction words. The first
// byte of a word lands in bits [7:0]. The full word and word_ready are
// presented combinationally in the cycle the last byte is accepted, so the
// parent can register the word straight into its memory-write outputs.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : restart packing at byte 0 (start of a new load)
//   byte_valid  : byte_data is accepted this cycle
//   byte_data   : incoming stream byte
//   word        : assembled word (valid when word_ready=1)
//   word_ready  : pulse, last byte of a word accepted this cycle
// ---------------------------------------------------------------------------
module byte_packer
  import loader_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic [W-1:0] word,
  output logic         word_ready
);

  logic [1:0]   cnt_q, cnt_d;
  // Only the first three bytes need storing; the fourth arrives with word_ready.
  logic [W-9:0] shreg_q, shreg_d;

  // Next-state for the byte counter and the shift-in register.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clear) begin
      cnt_d   = 2'd0;
      shreg_d = '0;
    end else if (byte_valid) begin
      cnt_d   = cnt_q + 2'd1;
      shreg_d = {byte_data, shreg_q[W-9:8]};
    end else begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
    end
  end

  assign word       = {byte_data, shreg_q};
  assign word_ready = byte_valid && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

  // Counter and shift register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Boot-time writer for the instruction memory. Takes a valid/ready byte
// stream: a 2-byte word count N (LSB first) followed by N little-endian
// 32-bit words, written sequentially from BASE_ADDR. The core is held in
// reset (cpu_rst=1) until the whole image has been written.
//
// Build option: define LOADER_CHECKSUM_EN to require one trailing byte equal
// to the XOR of all length and data bytes (a mismatch ends in ERROR).
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load_start      : pulse; starts a load from IDLE/DONE/ERROR
//   rx_data/valid   : stream byte and its valid
//   rx_ready        : loader accepts a byte (LEN, DATA, CSUM)
//   imem_we/addr/wdata : instruction memory write port (one cycle per word)
//   cpu_rst         : core reset, released only in DONE
//   busy/done/error : load in progress / image loaded / load aborted
//   words_loaded    : words written in the current or last load
// All outputs are registered.
// ---------------------------------------------------------------------------
module program_loader
  import loader_pkg::*;
#(
  parameter int                    PC_WIDTH    = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   BASE_ADDR   = {PC_WIDTH{1'b0}},
  parameter int                    MAX_WORDS   = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [15:0]            words_loaded
);

  state_e                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic                   len_cnt_q, len_cnt_d;
  logic [15:0]            words_q, words_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
  logic                   rx_ready_q, rx_ready_d;
  logic                   we_q, we_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  logic                   byte_xfer_s;
  logic                   pack_clear_s;
  logic                   pack_valid_s;
  logic [INSTR_WIDTH-1:0] pack_word_s;
  logic                   pack_ready_s;
  logic [15:0]            n_s;
  logic [PC_WIDTH-1:0]    word_off_s;
  state_e                 after_last_s;

  assign byte_xfer_s  = rx_valid && rx_ready_q;
  assign pack_valid_s = byte_xfer_s && (state_q == DATA);
  // Full word count, valid in the cycle the second header byte arrives.
  assign n_s          = {rx_data, len_q[7:0]};
  assign word_off_s   = PC_WIDTH'({words_q, 2'b00});
`ifdef LOADER_CHECKSUM_EN
  assign after_last_s = CSUM;
`else
  assign after_last_s = DONE;
`endif

  byte_packer #(
    .W(INSTR_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear_s),
    .byte_valid (pack_valid_s),
    .byte_data  (rx_data),
    .word       (pack_word_s),
    .word_ready (pack_ready_s)
  );

  // FSM next-state, datapath updates and registered output decode.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    len_cnt_d    = len_cnt_q;
    words_d      = words_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    pack_clear_s = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (load_start) begin
          state_d      = LEN;
          len_d        = 16'd0;
          len_cnt_d    = 1'b0;
          words_d      = 16'd0;
          pack_clear_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d       = 8'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      LEN: begin
        if (byte_xfer_s) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_update(csum_q, rx_data);
`endif
          if (len_cnt_q != 1'(LEN_BYTES - 1)) begin
            len_d[7:0] = rx_data;
            len_cnt_d  = len_cnt_q + 1'b1;
          end else begin
            len_d = n_s;
            if (n_s == 16'd0) begin
              state_d = after_last_s;
            end else if (32'(n_s) > 32'(MAX_WORDS)) begin
              state_d = ERROR;
            end else begin
              state_d = DATA;
            end
          end
        end else begin
          state_d = LEN;
        end
      end
      DATA: begin
        if (byte_xfer_s) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_update(csum_q, rx_data);
`endif
          if (pack_ready_s) begin
            state_d = WRITE;
            wdata_d = pack_word_s;
            addr_d  = BASE_ADDR + word_off_s;
            words_d = words_q + 16'd1;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      WRITE: begin
        // words_q already counts the word being written this cycle.
        if (words_q == len_q) begin
          state_d = after_last_s;
        end else begin
          state_d = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (byte_xfer_s) begin
          if (rx_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
          end
        end else begin
          state_d = CSUM;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    rx_ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
    we_d       = (state_d == WRITE);
    cpu_rst_d  = (state_d != DONE);
    busy_d     = (state_d == LEN) || (state_d == DATA) || (state_d == WRITE) || (state_d == CSUM);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERROR);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= 16'd0;
      len_cnt_q  <= 1'b0;
      words_q    <= 16'd0;
      addr_q     <= {PC_WIDTH{1'b0}};
      wdata_q    <= {INSTR_WIDTH{1'b0}};
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      len_cnt_q  <= len_cnt_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Directed bench for program_loader with hand-computed expected values.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;
  int we_count = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  logic [7:0] img2 [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
  int         gaps [10] = '{1, 0, 3, 2, 0, 1, 2, 0, 3, 1};

  program_loader dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Record every memory write seen on the falling edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      we_count++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val("byte_accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && error !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_val("end_timeout", 32'(n), 32'd0);
  endtask

  task automatic check_idle_reset(input string tag);
    check_val({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check_val({tag, "_we"}, 32'(imem_we), 32'd0);
    check_val({tag, "_addr"}, imem_addr, 32'h0);
    check_val({tag, "_wdata"}, imem_wdata, 32'h0);
    check_val({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_error"}, 32'(error), 32'd0);
    check_val({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic check_image2(input string tag);
    check_val({tag, "_nwrites"}, 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check_val({tag, "_addr0"}, wa_q[0], 32'h0000_0000);
      check_val({tag, "_data0"}, wd_q[0], 32'h0050_0513);
      check_val({tag, "_addr1"}, wa_q[1], 32'h0000_0004);
      check_val({tag, "_data1"}, wd_q[1], 32'h0010_0593);
    end
  endtask

  initial begin
    int base;

    // 1: reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_reset("t1");
    rst = 1'b0;
    @(negedge clk);
    check_val("t1_idle_rx_ready", 32'(rx_ready), 32'd0);

    // 2: two-word image, no gaps
    wa_q.delete(); wd_q.delete();
    pulse_start();
    check_val("t2_busy", 32'(busy), 32'd1);
    check_val("t2_rx_ready", 32'(rx_ready), 32'd1);
    check_val("t2_cpu_rst_held", 32'(cpu_rst), 32'd1);
    for (int i = 0; i < 10; i++) send_byte(img2[i], 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hC2, 0);
`endif
    wait_end();
    check_image2("t2");
    check_val("t2_done", 32'(done), 32'd1);
    check_val("t2_error", 32'(error), 32'd0);
    check_val("t2_cpu_rst", 32'(cpu_rst), 32'd0);
    check_val("t2_busy_end", 32'(busy), 32'd0);
    check_val("t2_words", 32'(words_loaded), 32'd2);

    // 3: empty image; restart from DONE clears done and reasserts cpu_rst
    base = we_count;
    pulse_start();
    check_val("t3_done_cleared", 32'(done), 32'd0);
    check_val("t3_cpu_rst", 32'(cpu_rst), 32'd1);
    check_val("t3_words_cleared", 32'(words_loaded), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    @(negedge clk);
    check_val("t3_done_next", 32'(done), 32'd1);
    check_val("t3_no_write", 32'(we_count - base), 32'd0);
    check_val("t3_words", 32'(words_loaded), 32'd0);

    // 4: length MAX_WORDS+1 = 257
    base = we_count;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    wait_end();
    check_val("t4_error", 32'(error), 32'd1);
    check_val("t4_done", 32'(done), 32'd0);
    check_val("t4_cpu_rst", 32'(cpu_rst), 32'd1);
    check_val("t4_rx_ready", 32'(rx_ready), 32'd0);
    repeat (3) @(negedge clk);
    check_val("t4_no_write", 32'(we_count - base), 32'd0);

    // 5a: image from test 2 with rx_valid gaps, restarted from ERROR
    wa_q.delete(); wd_q.delete();
    pulse_start();
    check_val("t5_error_cleared", 32'(error), 32'd0);
    for (int i = 0; i < 10; i++) send_byte(img2[i], gaps[i]);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hC2, 2);
`endif
    wait_end();
    check_image2("t5");
    check_val("t5_done", 32'(done), 32'd1);

    // 5b: reset after five bytes
    base = we_count;
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(img2[i], 0);
    @(negedge clk) rst = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_idle_reset("t5_rst");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rx_valid = 1'b0;
    check_val("t5_rst_no_write", 32'(we_count - base), 32'd0);
    check_val("t5_rst_idle_busy", 32'(busy), 32'd0);
    check_val("t5_rst_idle_ready", 32'(rx_ready), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // 6: bad checksum, then a correct image
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(img2[i], 0);
    send_byte(8'hC3, 0);
    wait_end();
    check_val("t6_error", 32'(error), 32'd1);
    check_val("t6_cpu_rst", 32'(cpu_rst), 32'd1);
    wa_q.delete(); wd_q.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(img2[i], 0);
    send_byte(8'hC2, 0);
    wait_end();
    check_image2("t6");
    check_val("t6_done", 32'(done), 32'd1);
    check_val("t6_cpu_rst_rel", 32'(cpu_rst), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
